// File: rtl/lcd_tmds_pkg.sv
// Shared constants for the greyscale DVI TMDS encoder: control symbols,
// reset symbol, disparity-counter width and small encoding helpers.
package lcd_tmds_pkg;

  localparam int CNT_W = 6;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] RESET_SYM = CTRL_00;

  // c = {c1, c0}
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage A (transition minimisation) and stage B (DC balance
// or control symbol), two registered stages with a private disparity counter.
module tmds_channel_enc
  import lcd_tmds_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       de,
  input  logic [7:0] dat,
  input  logic [1:0] c,
  output logic [9:0] tmds
);

  logic [8:0]             q_m_nxt;
  logic [8:0]             q_m;
  logic                   de_a;
  logic [1:0]             c_a;
  logic [3:0]             n1d;
  logic                   use_xnor;
  logic                   chain;
  logic [3:0]             n1q;
  logic signed [CNT_W-1:0] diff;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic [9:0]             sym;

  always_comb begin
    n1d      = ones8(dat);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !dat[0]);
    chain    = dat[0];
    q_m_nxt  = '0;
    q_m_nxt[0] = chain;
    for (int i = 1; i < 8; i++) begin
      chain      = use_xnor ? ~(chain ^ dat[i]) : (chain ^ dat[i]);
      q_m_nxt[i] = chain;
    end
    q_m_nxt[8] = ~use_xnor;
  end

  // diff = N1 - N0 of q_m[7:0] = 2*N1 - 8, range -8..+8
  always_comb begin
    n1q     = ones8(q_m[7:0]);
    diff    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    sym     = ctrl_sym(c_a);
    cnt_nxt = '0;
    if (de_a) begin
      if ((cnt == '0) || (diff == '0)) begin
        sym     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_nxt = q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if (cnt[CNT_W-1] == diff[CNT_W-1]) begin
        // both non-zero here, so equal signs mean the running disparity would grow
        sym     = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_nxt = cnt + $signed({4'b0000, q_m[8], 1'b0}) - diff;
      end else begin
        sym     = {1'b0, q_m[8], q_m[7:0]};
        cnt_nxt = cnt - $signed({4'b0000, ~q_m[8], 1'b0}) + diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_m  <= '0;
      de_a <= 1'b0;
      c_a  <= 2'b00;
      cnt  <= '0;
      tmds <= RESET_SYM;
    end else begin
      q_m  <= q_m_nxt;
      de_a <= de;
      c_a  <= c;
      cnt  <= cnt_nxt;
      tmds <= sym;
    end
  end

endmodule

// File: rtl/lcd_tmds_encoder.sv
// Greyscale-to-DVI TMDS encoder top: data-enable decode, optional bar test
// pattern (LCD_TMDS_TESTPAT_EN) and three channel encoders; sync rides on blue.
module lcd_tmds_encoder
  import lcd_tmds_pkg::*;
#(
  parameter bit DEN_ACTIVE_LOW = 1'b1,
  parameter int BAR_W          = 40
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] lcd_dat,
  input  logic       lcd_hsync,
  input  logic       lcd_vsync,
  input  logic       lcd_den,
`ifdef LCD_TMDS_TESTPAT_EN
  input  logic       test_en,
`endif
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_b
);

  logic       de;
  logic [7:0] enc_dat;

  assign de = lcd_den ^ DEN_ACTIVE_LOW;

`ifdef LCD_TMDS_TESTPAT_EN
  logic [9:0] pix_cnt;
  logic [2:0] bar_idx;
  logic [7:0] bar_byte;
  int         bar_raw;

  // counts active pixels already seen on this line; saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_cnt <= '0;
    end else if (!de) begin
      pix_cnt <= '0;
    end else if (pix_cnt != '1) begin
      pix_cnt <= pix_cnt + 10'd1;
    end
  end

  always_comb begin
    bar_raw  = int'(pix_cnt) / BAR_W;
    bar_idx  = (bar_raw > 7) ? 3'd7 : 3'(bar_raw);
    bar_byte = {5'b00000, bar_idx} * 8'd36;
    enc_dat  = test_en ? bar_byte : lcd_dat;
  end
`else
  assign enc_dat = lcd_dat;
`endif

  tmds_channel_enc u_enc_r (
    .clk    (clk),
    .resetn (resetn),
    .de     (de),
    .dat    (enc_dat),
    .c      (2'b00),
    .tmds   (tmds_r)
  );

  tmds_channel_enc u_enc_g (
    .clk    (clk),
    .resetn (resetn),
    .de     (de),
    .dat    (enc_dat),
    .c      (2'b00),
    .tmds   (tmds_g)
  );

  tmds_channel_enc u_enc_b (
    .clk    (clk),
    .resetn (resetn),
    .de     (de),
    .dat    (enc_dat),
    .c      ({lcd_vsync, lcd_hsync}),
    .tmds   (tmds_b)
  );

endmodule

// File: tb/tb_lcd_tmds_encoder.sv
// Self-checking bench for lcd_tmds_encoder: directed vector table, reset
// sequences, random lines against a reference encoder, optional test pattern.
module tb_lcd_tmds_encoder;

  localparam int BAR_W = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] lcd_dat = 8'h00;
  logic       lcd_hsync = 1'b1;
  logic       lcd_vsync = 1'b1;
  logic       lcd_den = 1'b1;
  logic       test_en = 1'b0;
  logic [9:0] tmds_r, tmds_g, tmds_b;

  always #20 clk = ~clk;

  lcd_tmds_encoder #(.DEN_ACTIVE_LOW(1'b1), .BAR_W(BAR_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .lcd_dat   (lcd_dat),
    .lcd_hsync (lcd_hsync),
    .lcd_vsync (lcd_vsync),
    .lcd_den   (lcd_den),
`ifdef LCD_TMDS_TESTPAT_EN
    .test_en   (test_en),
`endif
    .tmds_r    (tmds_r),
    .tmds_g    (tmds_g),
    .tmds_b    (tmds_b)
  );

  typedef struct {
    logic [9:0] r;
    logic [9:0] b;
    string      nm;
  } exp_t;

  typedef struct {
    logic       de;
    logic [7:0] dat;
    logic       hs;
    logic       vs;
    logic [9:0] er;
    logic [9:0] eb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   n_tests = 0;
  int   n_fail = 0;
  int   mcnt = 0;

  function automatic int ones(input int v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic logic [9:0] ctrl_of(input logic vs, input logic hs);
    logic [9:0] s;
    case ({vs, hs})
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

  // reference encoder working on integers; updates the bench's running disparity
  task automatic model_data(input int d, output logic [9:0] sym);
    int         n1, n0, qm, bit_v, prev, m8;
    bit         xn;
    logic [7:0] q8;
    n1 = ones(d);
    xn = (n1 > 4) || (n1 == 4 && (d & 1) == 0);
    qm = d & 1;
    for (int i = 1; i < 8; i++) begin
      prev  = (qm >> (i - 1)) & 1;
      bit_v = ((d >> i) & 1) ^ prev;
      if (xn) bit_v = bit_v ^ 1;
      qm = qm | (bit_v << i);
    end
    m8 = xn ? 0 : 1;
    q8 = qm[7:0];
    n1 = ones(qm);
    n0 = 8 - n1;
    if (mcnt == 0 || n1 == n0) begin
      if (m8 == 1) begin
        sym = {2'b01, q8};
        mcnt += n1 - n0;
      end else begin
        sym = {2'b10, ~q8};
        mcnt += n0 - n1;
      end
    end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
      sym = {1'b1, m8[0], ~q8};
      mcnt += 2 * m8 + n0 - n1;
    end else begin
      sym = {1'b0, m8[0], q8};
      mcnt += -2 * (1 - m8) + n1 - n0;
    end
    if (mcnt > 16 || mcnt < -16) begin
      $display("FAIL model_cnt_range: cnt %0d outside -16..16", mcnt);
      n_fail++;
    end
  endtask

  task automatic check3(input string nm, input logic [9:0] er, input logic [9:0] eb);
    n_tests++;
    if (tmds_r !== er || tmds_g !== er || tmds_b !== eb) begin
      n_fail++;
      $display("FAIL %s: got r=%h g=%h b=%h expected r=%h g=%h b=%h",
               nm, tmds_r, tmds_g, tmds_b, er, er, eb);
    end
  endtask

  task automatic drive(input logic de, input logic [7:0] d, input logic hs,
                       input logic vs, input logic [9:0] er, input logic [9:0] eb,
                       input string nm);
    exp_t e;
    @(negedge clk);
    lcd_den   = ~de;
    lcd_dat   = d;
    lcd_hsync = hs;
    lcd_vsync = vs;
    sb.push_back('{r: er, b: eb, nm: nm});
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check3(e.nm, e.r, e.b);
    end
  endtask

  task automatic drive_model(input logic de, input logic [7:0] d, input logic hs,
                             input logic vs, input string nm);
    logic [9:0] s;
    if (!de) begin
      mcnt = 0;
      drive(1'b0, d, hs, vs, 10'h354, ctrl_of(vs, hs), nm);
    end else begin
      model_data(int'(d), s);
      drive(1'b1, d, hs, vs, s, s, nm);
    end
  endtask

  task automatic apply_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      resetn    = 1'b0;
      lcd_den   = 1'b1;
      lcd_dat   = 8'h00;
      lcd_hsync = 1'b1;
      lcd_vsync = 1'b1;
      @(posedge clk);
      #1;
      check3("reset", 10'h354, 10'h354);
    end
    resetn = 1'b1;
    sb.delete();
    sb.push_back('{r: 10'h354, b: 10'h354, nm: "post_reset"});
    mcnt = 0;
  endtask

  initial begin
    //            de    dat    hs    vs    r        b
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB};
    vecs[1]  = '{1'b1, 8'h00, 1'b1, 1'b1, 10'h100, 10'h100};
    vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 10'h3FF, 10'h3FF};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h354, 10'h354};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h354, 10'h0AB};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'h354, 10'h154};
    vecs[6]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 10'h200, 10'h200};
    vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 10'h0FF, 10'h0FF};
    vecs[8]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 10'h0FF, 10'h0FF};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 10'h200, 10'h200};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 1'b1, 10'h133, 10'h133};
    vecs[12] = '{1'b1, 8'hAA, 1'b1, 1'b1, 10'h233, 10'h233};
    vecs[13] = '{1'b1, 8'h01, 1'b1, 1'b1, 10'h1FF, 10'h1FF};
    vecs[14] = '{1'b1, 8'h01, 1'b1, 1'b1, 10'h300, 10'h300};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB};
    vecs[16] = '{1'b1, 8'h00, 1'b1, 1'b1, 10'h100, 10'h100};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB};

    apply_reset(3);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].de, vecs[i].dat, vecs[i].hs, vecs[i].vs,
            vecs[i].er, vecs[i].eb, $sformatf("vec%0d", i));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB, "vec_flush");

    // reset in the middle of active video, then resume
    mcnt = 0;
    drive_model(1'b1, 8'hFF, 1'b1, 1'b1, "pre_rst0");
    drive_model(1'b1, 8'h3C, 1'b1, 1'b1, "pre_rst1");
    apply_reset(1);
    drive_model(1'b1, 8'h00, 1'b1, 1'b1, "mid_rst0");
    drive_model(1'b1, 8'h00, 1'b1, 1'b1, "mid_rst1");
    drive_model(1'b0, 8'h00, 1'b1, 1'b1, "mid_rst2");

    // random lines with random sync levels during blanking
    for (int line = 0; line < 3; line++) begin
      for (int k = 0; k < 12; k++) begin
        drive_model(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), "blank");
      end
      for (int p = 0; p < 1000; p++) begin
        drive_model(1'b1, 8'($urandom), 1'b1, 1'b1, $sformatf("line%0d_px%0d", line, p));
      end
    end
    drive_model(1'b0, 8'h00, 1'b0, 1'b0, "tail_blank0");

`ifdef LCD_TMDS_TESTPAT_EN
    test_en = 1'b1;
    for (int line = 0; line < 2; line++) begin
      drive_model(1'b0, 8'h00, 1'b1, 1'b1, "tp_blank");
      for (int p = 0; p < 310; p++) begin
        logic [9:0] s;
        int bi;
        bi = (p / BAR_W > 7) ? 7 : p / BAR_W;
        model_data(bi * 36, s);
        drive(1'b1, 8'($urandom), 1'b1, 1'b1, s, s, $sformatf("tp%0d_px%0d", line, p));
      end
    end
    mcnt = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b1, 10'h354, 10'h2AB, "tp_end");
    test_en = 1'b0;
`endif

    drive_model(1'b0, 8'h00, 1'b1, 1'b1, "final0");
    drive_model(1'b0, 8'h00, 1'b1, 1'b1, "final1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
